// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vram_pkg
// Purpose  : Shared geometry, widths, newline code and FSM state type for the
//            VRAM console controller.
// Revision : 1.0 - initial release
// ============================================================================
package vram_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int DEPTH  = 4800;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 11;

  localparam logic [7:0] NEWLINE = 8'h0A;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/console_cursor.sv
`default_nettype none
// ============================================================================
// Module   : console_cursor
// Purpose  : Row/column tracker keeping cursor = row*COLS + col incrementally.
// Revision : 1.0 - initial release
// ============================================================================
module console_cursor
  import vram_pkg::*;
#(
  parameter int COLS = vram_pkg::COLS,
  parameter int ROWS = vram_pkg::ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              newline,
  input  logic              zero,
  output logic [ADDR_W-1:0] cursor,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col
);

  localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_cols     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] c_col_last = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] c_row_last = ADDR_W'(ROWS - 1);

  logic [ADDR_W-1:0] r_cursor;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;

  always_ff @(posedge clk) begin
    if (rst || zero) begin
      r_cursor <= '0;
      r_row    <= '0;
      r_col    <= '0;
    end else if (advance) begin
      if (r_col == c_col_last) begin
        r_col <= '0;
        if (r_row == c_row_last) begin
          r_row    <= '0;
          r_cursor <= '0;
        end else begin
          r_row    <= r_row + c_one;
          r_cursor <= r_cursor + c_one;
        end
      end else begin
        r_col    <= r_col + c_one;
        r_cursor <= r_cursor + c_one;
      end
    end else if (newline) begin
      r_col <= '0;
      if (r_row == c_row_last) begin
        r_row    <= '0;
        r_cursor <= '0;
      end else begin
        // Start of next row: strip the column, add one full row.
        r_row    <= r_row + c_one;
        r_cursor <= r_cursor - r_col + c_cols;
      end
    end
  end

  assign cursor = r_cursor;
  assign row    = r_row;
  assign col    = r_col;

endmodule
`default_nettype wire

// File: rtl/vram_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vram_console_ctrl
// Purpose  : VRAM write arbiter for clear, direct CPU writes and a putc stream.
// Revision : 1.0 - initial release
// ============================================================================
module vram_console_ctrl
  import vram_pkg::*;
#(
  parameter int COLS  = vram_pkg::COLS,
  parameter int ROWS  = vram_pkg::ROWS,
  parameter int DEPTH = vram_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_clear,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_busy,
  input  logic              putc_valid,
  input  logic [DATA_W-1:0] putc_data,
  output logic              putc_ready,
  output logic [ADDR_W-1:0] cursor,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we
);

  localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_depth     = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [DATA_W-1:0] r_fill;
  logic              r_last_d;
  logic              r_clear_done;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;

  logic              w_issue;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;
  logic              w_adv;
  logic              w_nl;
  logic              w_zero;
  logic              w_start;
  logic              w_last;
  logic [ADDR_W-1:0] w_cursor;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;
  logic              w_unused_pos;

  assign cpu_busy   = (r_state == ST_CLEAR) | cmd_clear;
  assign putc_ready = (r_state == ST_IDLE) & ~cmd_clear & ~cpu_we;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_addr      = r_clr_addr;
    w_din       = r_fill;
    w_adv       = 1'b0;
    w_nl        = 1'b0;
    w_zero      = 1'b0;
    w_start     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_clear) begin
          w_state_nxt = ST_CLEAR;
          w_start     = 1'b1;
        end else if (cpu_we) begin
          if (cpu_addr < c_depth) begin
            w_issue = 1'b1;
            w_addr  = cpu_addr;
            w_din   = cpu_data;
          end
        end else if (putc_valid) begin
          if (putc_data[7:0] == NEWLINE) begin
            w_nl = 1'b1;
          end else begin
            w_issue = 1'b1;
            w_addr  = w_cursor;
            w_din   = putc_data;
            w_adv   = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        w_issue = 1'b1;
        if (r_clr_addr == c_last_addr) begin
          w_last      = 1'b1;
          w_zero      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_clr_addr   <= '0;
      r_fill       <= '0;
      r_last_d     <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_ram_we <= w_issue;
      if (w_issue) begin
        r_ram_addr <= w_addr;
        r_ram_din  <= w_din;
      end
      if (w_start) begin
        r_fill     <= fill_data;
        r_clr_addr <= '0;
      end else if (r_state == ST_CLEAR) begin
        r_clr_addr <= w_last ? '0 : r_clr_addr + c_one;
      end
      // Done trails the final ram_we by one cycle.
      r_last_d     <= w_last;
      r_clear_done <= r_last_d;
    end
  end

  console_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk     (clk),
    .rst     (rst),
    .advance (w_adv),
    .newline (w_nl),
    .zero    (w_zero),
    .cursor  (w_cursor),
    .row     (w_row),
    .col     (w_col)
  );

  assign w_unused_pos = &{1'b0, w_row, w_col};

  assign cursor     = w_cursor;
  assign clear_done = r_clear_done;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_din    = r_ram_din;

endmodule
`default_nettype wire

// File: tb/tb_vram_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_console_ctrl
// Purpose  : Directed self-checking bench for vram_console_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_console_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_clear;
  logic [10:0] fill_data;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [10:0] cpu_data;
  logic        cpu_busy;
  logic        putc_valid;
  logic [10:0] putc_data;
  logic        putc_ready;
  logic [12:0] cursor;
  logic        clear_done;
  logic [12:0] ram_addr;
  logic [10:0] ram_din;
  logic        ram_we;

  int n_chk  = 0;
  int n_fail = 0;

  vram_console_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_clear  (cmd_clear),
    .fill_data  (fill_data),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_busy   (cpu_busy),
    .putc_valid (putc_valid),
    .putc_data  (putc_data),
    .putc_ready (putc_ready),
    .cursor     (cursor),
    .clear_done (clear_done),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [10:0] cpu_data;
    logic        putc_valid;
    logic [10:0] putc_data;
    logic        e_ready;
    logic        e_busy;
    logic        e_we;
    logic [12:0] e_addr;
    logic [10:0] e_din;
    logic [12:0] e_cursor;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic putc(input logic [10:0] d);
    putc_valid = 1'b1;
    putc_data  = d;
    tick();
    putc_valid = 1'b0;
  endtask

  task automatic run_clear(input logic [10:0] fill, input bit with_cpu, input bit with_second);
    int writes   = 0;
    int bad      = 0;
    int busy_bad = 0;
    int dones    = 0;
    int cyc      = 0;
    cmd_clear = 1'b1;
    fill_data = fill;
    if (with_cpu) begin
      cpu_we   = 1'b1;
      cpu_addr = 13'd5;
      cpu_data = 11'h3FF;
    end
    #1;
    chk("clr_start_busy", 32'(cpu_busy), 32'd1);
    chk("clr_start_ready", 32'(putc_ready), 32'd0);
    tick();
    cmd_clear = 1'b0;
    cpu_we    = 1'b0;
    fill_data = ~fill;
    while (dones == 0 && cyc < 6000) begin
      if (ram_we) begin
        if (ram_addr !== 13'(writes) || ram_din !== fill) bad++;
        writes++;
      end
      if (cpu_busy !== (writes < 4800)) busy_bad++;
      if (clear_done) dones++;
      cmd_clear = with_second && (cyc == 1000);
      cyc++;
      if (dones == 0) tick();
    end
    cmd_clear = 1'b0;
    chk("clr_write_count", 32'(writes), 32'd4800);
    chk("clr_addr_data_errors", 32'(bad), 32'd0);
    chk("clr_busy_errors", 32'(busy_bad), 32'd0);
    chk("clr_done_pulses", 32'(dones), 32'd1);
    chk("clr_cursor", 32'(cursor), 32'd0);
    tick();
    chk("clr_done_single", 32'(clear_done), 32'd0);
    chk("clr_no_extra_we", 32'(ram_we), 32'd0);
  endtask

  initial begin
    int found;
    int n_we;
    int n_done;

    rst        = 1'b1;
    cmd_clear  = 1'b0;
    fill_data  = '0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_data   = '0;
    putc_valid = 1'b0;
    putc_data  = '0;

    //            we  addr       data      pv  pdata     rdy busy we  eaddr      edin     ecur
    vecs[0] = '{1'b0, 13'd0,    11'h000, 1'b1, 11'h041, 1'b1, 1'b0, 1'b1, 13'd0,    11'h041, 13'd1};
    vecs[1] = '{1'b0, 13'd0,    11'h000, 1'b1, 11'h042, 1'b1, 1'b0, 1'b1, 13'd1,    11'h042, 13'd2};
    vecs[2] = '{1'b1, 13'd100,  11'h7FF, 1'b1, 11'h043, 1'b0, 1'b0, 1'b1, 13'd100,  11'h7FF, 13'd2};
    vecs[3] = '{1'b0, 13'd0,    11'h000, 1'b1, 11'h043, 1'b1, 1'b0, 1'b1, 13'd2,    11'h043, 13'd3};
    vecs[4] = '{1'b1, 13'd4800, 11'h001, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0, 13'd0,    11'h000, 13'd3};
    vecs[5] = '{1'b0, 13'd0,    11'h000, 1'b1, 11'h10A, 1'b1, 1'b0, 1'b0, 13'd0,    11'h000, 13'd80};
    vecs[6] = '{1'b0, 13'd0,    11'h000, 1'b1, 11'h041, 1'b1, 1'b0, 1'b1, 13'd80,   11'h041, 13'd81};
    vecs[7] = '{1'b0, 13'd0,    11'h000, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0, 13'd0,    11'h000, 13'd81};
    vecs[8] = '{1'b1, 13'd4799, 11'h155, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 13'd4799, 11'h155, 13'd81};
    vecs[9] = '{1'b1, 13'd200,  11'h0AA, 1'b1, 11'h00A, 1'b0, 1'b0, 1'b1, 13'd200,  11'h0AA, 13'd81};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_cursor", 32'(cursor), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_cpu_busy", 32'(cpu_busy), 32'd0);
    chk("rst_putc_ready", 32'(putc_ready), 32'd1);

    run_clear(11'h020, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      cpu_we     = vecs[i].cpu_we;
      cpu_addr   = vecs[i].cpu_addr;
      cpu_data   = vecs[i].cpu_data;
      putc_valid = vecs[i].putc_valid;
      putc_data  = vecs[i].putc_data;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(putc_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_busy", i), 32'(cpu_busy), 32'(vecs[i].e_busy));
      tick();
      cpu_we     = 1'b0;
      putc_valid = 1'b0;
      chk($sformatf("vec%0d_we", i), 32'(ram_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
        chk($sformatf("vec%0d_din", i), 32'(ram_din), 32'(vecs[i].e_din));
      end
      chk($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(vecs[i].e_cursor));
    end

    // Clear racing a CPU write, plus a second strobe mid-clear.
    run_clear(11'h1AB, 1'b1, 1'b1);

    for (int i = 0; i < 79; i++) putc(11'h041);
    chk("row0_col79_cursor", 32'(cursor), 32'd79);
    putc(11'h00A);
    chk("nl_at_col79_we", 32'(ram_we), 32'd0);
    chk("nl_at_col79_cursor", 32'(cursor), 32'd80);
    for (int i = 0; i < 58; i++) putc(11'h00A);
    chk("row59_cursor", 32'(cursor), 32'd4720);
    for (int i = 0; i < 79; i++) putc(11'h041);
    chk("last_cell_cursor", 32'(cursor), 32'd4799);
    putc(11'h041);
    chk("last_cell_we", 32'(ram_we), 32'd1);
    chk("last_cell_addr", 32'(ram_addr), 32'd4799);
    chk("last_cell_din", 32'(ram_din), 32'h041);
    chk("wrap_cursor", 32'(cursor), 32'd0);
    for (int i = 0; i < 80; i++) putc(11'h042);
    chk("col_wrap_cursor", 32'(cursor), 32'd80);
    for (int i = 0; i < 58; i++) putc(11'h00A);
    chk("row59_again_cursor", 32'(cursor), 32'd4720);
    putc(11'h00A);
    chk("nl_row_wrap_we", 32'(ram_we), 32'd0);
    chk("nl_row_wrap_cursor", 32'(cursor), 32'd0);

    // Reset while the clear is about to write address 2000.
    cmd_clear = 1'b1;
    fill_data = 11'h055;
    tick();
    cmd_clear = 1'b0;
    found = 0;
    for (int c = 0; c < 3000 && found == 0; c++) begin
      if (ram_we && ram_addr == 13'd1999) found = 1;
      else tick();
    end
    chk("abort_reached_1999", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_we_low", 32'(ram_we), 32'd0);
    n_we   = 0;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (ram_we) n_we++;
      if (clear_done) n_done++;
      tick();
    end
    chk("abort_no_writes", 32'(n_we), 32'd0);
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_busy", 32'(cpu_busy), 32'd0);
    chk("abort_ready", 32'(putc_ready), 32'd1);
    chk("abort_cursor", 32'(cursor), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_console_ctrl.md
VRAM_CONSOLE_CTRL -- requirements
Module: vram_console_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameters SHALL be: COLS, default 80, characters per row; ROWS, default 60, rows per screen; DEPTH, default 4800, VRAM entries (COLS*ROWS).
REQ-003 Ports SHALL be, in order:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- cmd_clear  in  1  one-cycle strobe; fill the whole VRAM with fill_data
- fill_data  in  11  entry value written by a clear
- cpu_we  in  1  one-cycle strobe; direct write request
- cpu_addr  in  13  direct write address
- cpu_data  in  11  direct write data
- cpu_busy  out  1  direct writes are not accepted
- putc_valid  in  1  character stream valid
- putc_data  in  11  character entry
- putc_ready  out  1  character stream ready
- cursor  out  13  next putc address
- clear_done  out  1  one-cycle pulse when a clear completes
- ram_addr  out  13  to VRAM write address
- ram_din  out  11  to VRAM write data
- ram_we  out  1  to VRAM write enable

Function
REQ-004 The FSM SHALL have two states: IDLE and CLEAR.
REQ-005 ram_addr, ram_din and ram_we SHALL be registered; every accepted write appears on them exactly one cycle after acceptance, with ram_we high for one cycle.
REQ-006 Priority in IDLE, in a single cycle: cmd_clear > cpu_we > putc.
REQ-007 cpu_busy SHALL equal (state==CLEAR) OR cmd_clear; a cpu_we asserted while cpu_busy=1 is dropped without a write.
REQ-008 A direct write SHALL NOT move the cursor; a cpu_addr >= DEPTH is dropped (no ram_we).
REQ-009 putc_ready SHALL equal (state==IDLE) AND NOT cmd_clear AND NOT cpu_we; a transfer occurs on putc_valid AND putc_ready.
REQ-010 On transfer with putc_data[7:0] != 8'h0A: write putc_data at cursor; col increments; at col=COLS-1, col->0 and row increments; at row=ROWS-1, col=COLS-1, cursor wraps to 0.
REQ-011 On transfer with putc_data[7:0] == 8'h0A: no write; col->0 and row increments; from row ROWS-1, row->0.
REQ-012 cursor SHALL be maintained incrementally as row*COLS+col, without a multiplier or divider, and SHALL update in the cycle after the transfer.
REQ-013 cmd_clear in IDLE SHALL enter CLEAR and write fill_data (latched at the strobe) to addresses 0..DEPTH-1, one per cycle, taking DEPTH consecutive ram_we cycles.
REQ-014 cmd_clear during CLEAR SHALL be ignored; the running clear is not restarted.
REQ-015 At clear completion: clear_done pulses one cycle, aligned with the cycle after the final ram_we; cursor, row and col reset to 0; state returns to IDLE.
REQ-016 The address counter SHALL be 13 bits and SHALL never emit an address >= DEPTH.

Reset
REQ-017 rst SHALL force: state=IDLE; cursor, row, col = 0; ram_we=0; ram_addr=0; ram_din=0; clear_done=0.
REQ-018 rst asserted mid-clear SHALL abort the clear: no further writes and no clear_done pulse.
REQ-019 After rst, cpu_busy=0 and putc_ready=1, unless the stall inputs are asserted.

Structure
REQ-020 The shared package vram_pkg SHALL hold COLS, ROWS, DEPTH, the newline code 8'h0A, address and data widths (13/11), and the state enum.
REQ-021 The row/col/cursor tracker SHALL be one sub-module, console_cursor, with inputs advance, newline, zero and outputs cursor, row, col.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- rst, then cmd_clear with fill_data=11'h020 -> 4800 ram_we cycles on addresses 0..4799 with data 020; clear_done pulses once; cursor=0.
- putc "A"(0x041), "B"(0x042) after a clear -> writes addr0=041 and addr1=042; cursor=2.
- Cursor at 79, putc 0x0A -> no ram_we; cursor=80. Cursor at 4799, putc 0x041 -> write at 4799; cursor=0.
- cpu_we(addr 100, data 7FF) in the same cycle as putc_valid -> only the cpu write occurs; putc_ready=0; putc transfers on the next cycle.
- cmd_clear and cpu_we in the same cycle -> cpu write dropped; cpu_busy=1 throughout the clear; a second cmd_clear mid-clear is ignored (still exactly 4800 writes).
- rst at clear address 2000 -> ram_we low from the next cycle; no clear_done; state=IDLE.
